// File: rtl/pipeline_sequencer.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stall, EX redirect flush,
// multi-cycle data-memory handshake with timeout, and saturating stall/flush counters.
module pipeline_sequencer #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_redirect,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_we,
    output logic              memwb_flush,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_WAIT = 2'd1, M_ERR = 2'd2} mstate_e;

    mstate_e          state_q, state_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mem_req_c, mem_stall_c, lu_c;

    assign mem_req_c = mem_rd | mem_wr;

    assign lu_c = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= M_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and wait/timeout bookkeeping
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            M_IDLE: begin
                if (mem_req_c && !dmem_ready) begin
                    state_d    = M_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            M_WAIT: begin
                if (dmem_ready) begin
                    state_d    = M_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
                    state_d = M_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            M_ERR:   state_d = M_ERR;
            default: state_d = M_IDLE;
        endcase
        mem_err_d = mem_err_q || (state_d == M_ERR);
    end

    // Outputs: memory handshake, then hazard priority mem_stall > redirect > load-use
    always_comb begin
        dmem_req    = 1'b0;
        mem_stall_c = 1'b0;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        memwb_flush = 1'b0;
        case (state_q)
            M_IDLE: begin
                dmem_req    = mem_req_c;
                mem_stall_c = mem_req_c && !dmem_ready;
            end
            M_WAIT: begin
                dmem_req    = 1'b1;
                mem_stall_c = !dmem_ready;
            end
            default: begin
                dmem_req    = 1'b0;
                mem_stall_c = 1'b1;
            end
        endcase
        if (mem_stall_c) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_c) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
        if (reset) begin
            dmem_req    = 1'b0;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end
    end

    // Timeout counter, sticky error and saturating perf counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            if ((mem_stall_c || (lu_c && !ex_redirect)) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ex_redirect && !mem_stall_c && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a cycle-level behavioural model checked
// on every falling edge, plus hand-computed literal expectations.
module tb_pipeline_sequencer;

    localparam int unsigned MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
    logic        mem_rd, mem_wr, dmem_ready;
    logic        dmem_req, pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_flush, mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_sequencer dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: consecutive unfinished cycles of the current access, error flag, counters
    int          m_stalls = 0;
    logic        m_err    = 1'b0;
    logic [15:0] m_scnt   = '0;
    logic [15:0] m_fcnt   = '0;
    logic        e_ms, e_lu, e_dreq;
    logic [6:0]  e_vec;

    // Expected combinational outputs {dmem_req,pc_we,ifid_we,ifid_flush,idex_flush,exmem_we,memwb_flush}
    always_comb begin
        if (m_err)             begin e_dreq = 1'b0;            e_ms = 1'b1; end
        else if (m_stalls > 0) begin e_dreq = 1'b1;            e_ms = !dmem_ready; end
        else                   begin e_dreq = mem_rd | mem_wr; e_ms = (mem_rd | mem_wr) & !dmem_ready; end
        e_lu = ex_memread && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (reset)            e_vec = 7'b0001101;
        else if (e_ms)        e_vec = {e_dreq, 6'b000001};
        else if (ex_redirect) e_vec = {e_dreq, 6'b111110};
        else if (e_lu)        e_vec = {e_dreq, 6'b000110};
        else                  e_vec = {e_dreq, 6'b110010};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_stalls <= 0; m_err <= 1'b0; m_scnt <= '0; m_fcnt <= '0;
        end else begin
            if (!m_err) begin
                if (e_ms) begin
                    m_stalls <= m_stalls + 1;
                    if (m_stalls + 1 == MEM_TIMEOUT + 1) m_err <= 1'b1;
                end else begin
                    m_stalls <= 0;
                end
            end
            if ((e_ms || (e_lu && !ex_redirect)) && m_scnt != 16'hFFFF) m_scnt <= m_scnt + 16'd1;
            if (ex_redirect && !e_ms && m_fcnt != 16'hFFFF) m_fcnt <= m_fcnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        chk("ctrl_vec", 32'({dmem_req, pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_flush}),
            32'(e_vec));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    endtask

    int reqs, stl, wbf;

    initial begin
        reset = 1'b1;
        clr();
        mem_rd = 1'b0; mem_wr = 1'b0; dmem_ready = 1'b0;
        #2;
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        nxt(); nxt();
        reset = 1'b0;
        #1;
        chk("post_rst_stall", 32'(stall_cnt), 32'd0);
        chk("post_rst_pc_we", 32'(pc_we), 32'd1);

        // Load-use on rs1
        nxt();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        chk("lu_pc_we", 32'(pc_we), 32'd0);
        chk("lu_ifid_we", 32'(ifid_we), 32'd0);
        chk("lu_idex_flush", 32'(idex_flush), 32'd1);
        chk("lu_exmem_we", 32'(exmem_we), 32'd1);
        nxt(); clr();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // No stall with ex_rd=0 or unused rs1; then stall via rs2
        ex_memread = 1'b1; id_use_rs1 = 1'b1;
        #1; chk("x0_pc_we", 32'(pc_we), 32'd1);
        nxt();
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
        #1; chk("nouse_pc_we", 32'(pc_we), 32'd1);
        nxt();
        id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        #1; chk("lu_rs2_ifid_we", 32'(ifid_we), 32'd0);
        nxt(); clr();
        chk("lu_rs2_stall_cnt", 32'(stall_cnt), 32'd2);

        // Redirect overrides load-use
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
        #1;
        chk("redir_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("redir_idex_flush", 32'(idex_flush), 32'd1);
        chk("redir_pc_we", 32'(pc_we), 32'd1);
        nxt(); clr();
        chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("redir_stall_cnt", 32'(stall_cnt), 32'd2);

        // Load with ready after 3 wait cycles; a redirect during the stall is ignored
        mem_rd = 1'b1;
        reqs = 0; stl = 0; wbf = 0;
        for (int i = 0; i < 4; i++) begin
            dmem_ready  = (i == 3);
            ex_redirect = (i == 1);
            #1;
            reqs += int'(dmem_req); stl += int'(!pc_we); wbf += int'(memwb_flush);
            nxt();
        end
        mem_rd = 1'b0; ex_redirect = 1'b0;
        chk("mem_req_cycles", 32'(reqs), 32'd4);
        chk("mem_stall_cycles", 32'(stl), 32'd3);
        chk("mem_wbflush_cycles", 32'(wbf), 32'd3);
        chk("mem_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("mem_flush_cnt", 32'(flush_cnt), 32'd1);
        #1;
        chk("ready_noreq_dmem_req", 32'(dmem_req), 32'd0);
        chk("ready_noreq_pc_we", 32'(pc_we), 32'd1);
        nxt();
        dmem_ready = 1'b0;

        // Reset in the middle of a wait
        mem_rd = 1'b1;
        nxt(); nxt();
        reset = 1'b1;
        #1;
        chk("rstwait_dmem_req", 32'(dmem_req), 32'd0);
        chk("rstwait_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rstwait_idex_flush", 32'(idex_flush), 32'd1);
        chk("rstwait_stall_cnt", 32'(stall_cnt), 32'd0);
        nxt();
        reset = 1'b0; mem_rd = 1'b0;
        #1; chk("after_rst_dmem_req", 32'(dmem_req), 32'd0);
        nxt();
        mem_wr = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("zero_wait_req", 32'(dmem_req), 32'd1);
        chk("zero_wait_pc_we", 32'(pc_we), 32'd1);
        nxt();

        // Store that never completes: timeout
        dmem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            nxt();
            if (i == 15) chk("timeout_edge15_err", 32'(mem_err), 32'd0);
            if (i == 16) chk("timeout_edge16_err", 32'(mem_err), 32'd1);
        end
        dmem_ready = 1'b1;
        #1;
        chk("err_dmem_req", 32'(dmem_req), 32'd0);
        chk("err_pc_we", 32'(pc_we), 32'd0);
        chk("err_memwb_flush", 32'(memwb_flush), 32'd1);
        nxt();
        mem_wr = 1'b0; dmem_ready = 1'b0;
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        nxt();
        chk("final_mem_err", 32'(mem_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
